// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the programmable synchronous FIFO
package fifo_pkg;

  localparam int unsigned FIFO_CNT_EXTRA = 1;

  function automatic int unsigned fifo_cnt_width(input int unsigned addrsize);
    return addrsize + FIFO_CNT_EXTRA;
  endfunction

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_prog_mem.sv
// rtl/sync_fifo_prog_mem.sv - DEPTH x DATASIZE storage, synchronous write, asynchronous read
module sync_fifo_prog_mem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk_i,
  input  logic                wen_acc,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem_q [2**ADDRSIZE];

  always_ff @(posedge clk_i) begin
    if (wen_acc) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds, count, sticky errors, optional FWFT
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int FWFT     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATASIZE-1:0]   din,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATASIZE-1:0]   dout,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  input  logic [ADDRSIZE:0]     af_thresh,
  input  logic [ADDRSIZE:0]     ae_thresh,
  output logic [ADDRSIZE:0]     fifo_count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW = fifo_cnt_width(ADDRSIZE);
  localparam logic [CW-1:0] DEPTH_C = CW'(2**ADDRSIZE);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATASIZE-1:0] dout_q, dout_d, rdata;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                wr_acc, rd_acc;
  fifo_flags_t         flags;

  // Flags come from the registered count only, never from wen/ren.
  always_comb begin
    flags              = '0;
    flags.full         = (count_q == DEPTH_C);
    flags.empty        = (count_q == '0);
    flags.almost_full  = (count_q >= af_thresh);
    flags.almost_empty = (count_q <= ae_thresh);
    flags.overflow     = ovf_q;
    flags.underflow    = unf_q;
  end

  assign fifo_full         = flags.full;
  assign fifo_empty        = flags.empty;
  assign fifo_almost_full  = flags.almost_full;
  assign fifo_almost_empty = flags.almost_empty;
  assign overflow          = flags.overflow;
  assign underflow         = flags.underflow;
  assign fifo_count        = count_q;

  always_comb begin
    wr_acc   = wen && !flags.full;
    rd_acc   = ren && !flags.empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A set on the same cycle as clr_err takes priority.
    ovf_d  = (wen && flags.full)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    unf_d  = (ren && flags.empty) ? 1'b1 : (clr_err ? 1'b0 : unf_q);
    dout_d = (MODE == FIFO_STD && rd_acc) ? rdata : dout_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_prog_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk_i   (clk_i),
    .wen_acc (wr_acc),
    .waddr   (wr_ptr_q),
    .wdata   (din),
    .raddr   (rd_ptr_q),
    .rdata   (rdata)
  );

  // FWFT exposes the head word directly; standard mode presents the read register.
  assign dout = (MODE == FIFO_FWFT) ? rdata : dout_q;

endmodule
